// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with a data-cache sequencer: fields appear one cycle after capture,
// loads/stores hold dmemREN/dmemWEN until dhit while mem_stall holds the upstream stages.
module ex_mem_latch #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              regwrite,
  input  logic [1:0]        memtoreg,
  input  logic              request_dmemREN,
  input  logic              request_dmemWEN,
  input  logic              halt_out,
  input  logic [WORD_W-1:0] NPC,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] rdat_two,
  input  logic [4:0]        wsel,
  input  logic [WORD_W-1:0] imemload,
  input  logic [WORD_W-1:0] uppersixteen,
  input  logic              stall,
  input  logic              flush,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              regwrite_ex_mem_output,
  output logic [1:0]        memtoreg_ex_mem_output,
  output logic              halt_out_ex_mem_output,
  output logic [WORD_W-1:0] NPC_ex_mem_output,
  output logic [WORD_W-1:0] alu_result_ex_mem_output,
  output logic [WORD_W-1:0] imemload_ex_mem_output,
  output logic [WORD_W-1:0] uppersixteen_ex_mem_output,
  output logic [4:0]        wsel_ex_mem_output,
  output logic [WORD_W-1:0] load_data_ex_mem_output
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q;
  logic              ren_q, wen_q, mem_stall_q;
  logic              regwrite_q, halt_q;
  logic [1:0]        memtoreg_q;
  logic [4:0]        wsel_q;
  logic [WORD_W-1:0] npc_q, alu_q, rdat_q, imem_q, upper_q, load_q;

  logic not_busy, bubble, capture;

  // A flush outside ACCESS always inserts a bubble, even under stall.
  assign not_busy = (state_q != ACCESS);
  assign bubble   = not_busy & flush;
  assign capture  = not_busy & ~stall & ~flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      mem_stall_q <= 1'b0;
      regwrite_q  <= 1'b0;
      halt_q      <= 1'b0;
      memtoreg_q  <= '0;
      wsel_q      <= '0;
      npc_q       <= '0;
      alu_q       <= '0;
      rdat_q      <= '0;
      imem_q      <= '0;
      upper_q     <= '0;
      load_q      <= '0;
    end else if (state_q == ACCESS) begin
      if (dhit) begin
        load_q      <= ren_q ? dmemload : '0;
        ren_q       <= 1'b0;
        wen_q       <= 1'b0;
        mem_stall_q <= 1'b0;
        state_q     <= DONE;
      end
    end else if (bubble) begin
      state_q     <= IDLE;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      mem_stall_q <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= '0;
      wsel_q      <= '0;
      npc_q       <= '0;
      alu_q       <= '0;
      rdat_q      <= '0;
      imem_q      <= '0;
      upper_q     <= '0;
      load_q      <= '0;
    end else if (capture) begin
      // A simultaneous load+store request is treated as a load.
      state_q     <= (request_dmemREN | request_dmemWEN) ? ACCESS : IDLE;
      ren_q       <= request_dmemREN;
      wen_q       <= request_dmemWEN & ~request_dmemREN;
      mem_stall_q <= request_dmemREN | request_dmemWEN;
      regwrite_q  <= regwrite;
      halt_q      <= halt_q | halt_out;
      memtoreg_q  <= memtoreg;
      wsel_q      <= wsel;
      npc_q       <= NPC;
      alu_q       <= alu_result;
      rdat_q      <= rdat_two;
      imem_q      <= imemload;
      upper_q     <= uppersixteen;
      load_q      <= '0;
    end
  end

  assign dmemREN                    = ren_q;
  assign dmemWEN                    = wen_q;
  assign mem_stall                  = mem_stall_q;
  assign dmemaddr                   = alu_q;
  assign dmemstore                  = rdat_q;
  assign regwrite_ex_mem_output     = regwrite_q;
  assign memtoreg_ex_mem_output     = memtoreg_q;
  assign halt_out_ex_mem_output     = halt_q;
  assign NPC_ex_mem_output          = npc_q;
  assign alu_result_ex_mem_output   = alu_q;
  assign imemload_ex_mem_output     = imem_q;
  assign uppersixteen_ex_mem_output = upper_q;
  assign wsel_ex_mem_output         = wsel_q;
  assign load_data_ex_mem_output    = load_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for ex_mem_latch: reset, ALU pass-through, load/store sequencing, flush, stall hold, halt.
module tb_ex_mem_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        regwrite, request_dmemREN, request_dmemWEN, halt_out, stall, flush, dhit;
  logic [1:0]  memtoreg;
  logic [31:0] NPC, alu_result, rdat_two, imemload, uppersixteen, dmemload;
  logic [4:0]  wsel;
  logic        dmemREN, dmemWEN, mem_stall, regwrite_o, halt_o;
  logic [1:0]  memtoreg_o;
  logic [31:0] dmemaddr, dmemstore, npc_o, alu_o, imem_o, upper_o, load_o;
  logic [4:0]  wsel_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  ex_mem_latch #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .regwrite(regwrite), .memtoreg(memtoreg),
    .request_dmemREN(request_dmemREN), .request_dmemWEN(request_dmemWEN),
    .halt_out(halt_out), .NPC(NPC), .alu_result(alu_result), .rdat_two(rdat_two),
    .wsel(wsel), .imemload(imemload), .uppersixteen(uppersixteen),
    .stall(stall), .flush(flush), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall),
    .regwrite_ex_mem_output(regwrite_o), .memtoreg_ex_mem_output(memtoreg_o),
    .halt_out_ex_mem_output(halt_o), .NPC_ex_mem_output(npc_o),
    .alu_result_ex_mem_output(alu_o), .imemload_ex_mem_output(imem_o),
    .uppersixteen_ex_mem_output(upper_o), .wsel_ex_mem_output(wsel_o),
    .load_data_ex_mem_output(load_o)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_nop();
    regwrite = 0; memtoreg = 0; request_dmemREN = 0; request_dmemWEN = 0;
    halt_out = 0; NPC = 0; alu_result = 0; rdat_two = 0; wsel = 0;
    imemload = 0; uppersixteen = 0; stall = 0; flush = 0; dhit = 0; dmemload = 0;
  endtask

  task automatic test_reset();
    drive_nop();
    nRST = 0;
    #12;
    total_cnt++; if ({dmemREN, dmemWEN, mem_stall, regwrite_o, halt_o} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {dmemREN, dmemWEN, mem_stall, regwrite_o, halt_o}); else pass_cnt++;
    total_cnt++; if ({alu_o, npc_o, load_o, dmemaddr} !== 128'h0) $display("FAIL reset_data got %h want 0", {alu_o, npc_o, load_o, dmemaddr}); else pass_cnt++;
    @(negedge CLK); nRST = 1;
    step();
  endtask

  task automatic test_alu();
    regwrite = 1; alu_result = 32'h0000_1234; wsel = 5; memtoreg = 2'd2;
    NPC = 32'h0000_0040; uppersixteen = 32'h1234_0000; imemload = 32'h2001_1234;
    step();
    total_cnt++; if (alu_o !== 32'h1234) $display("FAIL alu_result got %h want 00001234", alu_o); else pass_cnt++;
    total_cnt++; if (wsel_o !== 5'd5 || regwrite_o !== 1'b1 || memtoreg_o !== 2'd2) $display("FAIL alu_ctrl got wsel=%0d rw=%b m2r=%0d want 5/1/2", wsel_o, regwrite_o, memtoreg_o); else pass_cnt++;
    total_cnt++; if (npc_o !== 32'h40 || upper_o !== 32'h1234_0000 || imem_o !== 32'h2001_1234) $display("FAIL alu_fields got %h %h %h", npc_o, upper_o, imem_o); else pass_cnt++;
    total_cnt++; if (mem_stall !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) $display("FAIL alu_nostall got stall=%b ren=%b wen=%b want 000", mem_stall, dmemREN, dmemWEN); else pass_cnt++;
    drive_nop();
    step();
    total_cnt++; if (regwrite_o !== 1'b0 || alu_o !== 32'h0) $display("FAIL alu_nop got rw=%b alu=%h want 0/0", regwrite_o, alu_o); else pass_cnt++;
  endtask

  task automatic test_load();
    request_dmemREN = 1; alu_result = 32'h100; regwrite = 1; wsel = 8; memtoreg = 2'd1;
    step();
    drive_nop();
    regwrite = 1; alu_result = 32'h55; wsel = 3;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h100 || mem_stall !== 1'b1) $display("FAIL load_access%0d got ren=%b addr=%h stall=%b want 1/100/1", i, dmemREN, dmemaddr, mem_stall); else pass_cnt++;
      if (i == 2) begin dhit = 1; dmemload = 32'hDEAD_BEEF; end
      step();
    end
    dhit = 0; dmemload = 32'h0;
    total_cnt++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) $display("FAIL load_done_req got ren=%b stall=%b want 0/0", dmemREN, mem_stall); else pass_cnt++;
    total_cnt++; if (load_o !== 32'hDEAD_BEEF || alu_o !== 32'h100 || wsel_o !== 5'd8) $display("FAIL load_done_data got ld=%h alu=%h wsel=%0d want deadbeef/100/8", load_o, alu_o, wsel_o); else pass_cnt++;
    step();
    total_cnt++; if (alu_o !== 32'h55 || wsel_o !== 5'd3 || load_o !== 32'h0) $display("FAIL load_next got alu=%h wsel=%0d ld=%h want 55/3/0", alu_o, wsel_o, load_o); else pass_cnt++;
    drive_nop();
    step();
  endtask

  task automatic test_store();
    request_dmemWEN = 1; alu_result = 32'h200; rdat_two = 32'hCAFE_F00D;
    dhit = 1; dmemload = 32'h1111_1111;
    step();
    total_cnt++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || mem_stall !== 1'b1) $display("FAIL store_req got wen=%b ren=%b stall=%b want 1/0/1", dmemWEN, dmemREN, mem_stall); else pass_cnt++;
    total_cnt++; if (dmemstore !== 32'hCAFE_F00D || dmemaddr !== 32'h200) $display("FAIL store_data got st=%h addr=%h want cafef00d/200", dmemstore, dmemaddr); else pass_cnt++;
    drive_nop();
    dhit = 1; dmemload = 32'h1111_1111;
    step();
    dhit = 0;
    total_cnt++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0 || load_o !== 32'h0) $display("FAIL store_done got wen=%b stall=%b ld=%h want 0/0/0", dmemWEN, mem_stall, load_o); else pass_cnt++;
    drive_nop();
    request_dmemREN = 1; request_dmemWEN = 1; alu_result = 32'h300;
    step();
    total_cnt++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0) $display("FAIL both_req got ren=%b wen=%b want 1/0", dmemREN, dmemWEN); else pass_cnt++;
    drive_nop();
    dhit = 1; dmemload = 32'h0BAD_F00D;
    step();
    drive_nop();
    total_cnt++; if (load_o !== 32'h0BAD_F00D) $display("FAIL both_load got %h want 0badf00d", load_o); else pass_cnt++;
    step();
  endtask

  task automatic test_flush();
    halt_out = 1;
    step();
    halt_out = 0;
    total_cnt++; if (halt_o !== 1'b1) $display("FAIL halt_set got %b want 1", halt_o); else pass_cnt++;
    request_dmemREN = 1; alu_result = 32'h340; wsel = 9; regwrite = 1;
    step();
    drive_nop();
    flush = 1;
    step();
    total_cnt++; if (dmemREN !== 1'b1 || mem_stall !== 1'b1 || alu_o !== 32'h340) $display("FAIL flush_ignored got ren=%b stall=%b alu=%h want 1/1/340", dmemREN, mem_stall, alu_o); else pass_cnt++;
    flush = 0; dhit = 1; dmemload = 32'hA5A5_5A5A;
    step();
    dhit = 0;
    total_cnt++; if (load_o !== 32'hA5A5_5A5A || dmemREN !== 1'b0) $display("FAIL flush_complete got ld=%h ren=%b want a5a55a5a/0", load_o, dmemREN); else pass_cnt++;
    flush = 1; regwrite = 1; alu_result = 32'h999; wsel = 7; NPC = 32'h80;
    step();
    total_cnt++; if (alu_o !== 32'h0 || wsel_o !== 5'd0 || regwrite_o !== 1'b0 || npc_o !== 32'h0 || load_o !== 32'h0) $display("FAIL flush_bubble got alu=%h wsel=%0d rw=%b npc=%h ld=%h want all 0", alu_o, wsel_o, regwrite_o, npc_o, load_o); else pass_cnt++;
    total_cnt++; if (halt_o !== 1'b1) $display("FAIL flush_halt got %b want 1", halt_o); else pass_cnt++;
    drive_nop();
    step();
  endtask

  task automatic test_stall_hold();
    request_dmemREN = 1; alu_result = 32'h400; wsel = 4;
    step();
    drive_nop();
    dhit = 1; dmemload = 32'h1234_5678;
    step();
    drive_nop();
    stall = 1; request_dmemREN = 1; alu_result = 32'h777; wsel = 1; dhit = 1; dmemload = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++; if (alu_o !== 32'h400 || load_o !== 32'h1234_5678 || dmemREN !== 1'b0 || mem_stall !== 1'b0) $display("FAIL stall_hold%0d got alu=%h ld=%h ren=%b stall=%b want 400/12345678/0/0", i, alu_o, load_o, dmemREN, mem_stall); else pass_cnt++;
    end
    flush = 1;
    step();
    total_cnt++; if (alu_o !== 32'h0 || load_o !== 32'h0 || dmemREN !== 1'b0 || halt_o !== 1'b1) $display("FAIL stall_flush got alu=%h ld=%h ren=%b halt=%b want 0/0/0/1", alu_o, load_o, dmemREN, halt_o); else pass_cnt++;
    drive_nop();
    step();
  endtask

  task automatic test_reset_mid_access();
    request_dmemREN = 1; alu_result = 32'h500; regwrite = 1;
    step();
    drive_nop();
    total_cnt++; if (dmemREN !== 1'b1) $display("FAIL rst_pre got ren=%b want 1", dmemREN); else pass_cnt++;
    #2 nRST = 0;
    #1;
    total_cnt++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || alu_o !== 32'h0 || halt_o !== 1'b0 || regwrite_o !== 1'b0) $display("FAIL rst_async got ren=%b stall=%b alu=%h halt=%b rw=%b want all 0", dmemREN, mem_stall, alu_o, halt_o, regwrite_o); else pass_cnt++;
    @(negedge CLK); nRST = 1;
    regwrite = 1; alu_result = 32'h66;
    step();
    total_cnt++; if (alu_o !== 32'h66 || mem_stall !== 1'b0) $display("FAIL rst_idle got alu=%h stall=%b want 66/0", alu_o, mem_stall); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_flush();
    test_stall_hold();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
